mult_dispatcher: RTL
====================

// Module: mult_dispatcher
// PURPOSE
//  Operand queue and issue/collect stage wrapped around the add-shift multiplier.
//  - Buffers {multiplicand, multiplier} pairs from a valid/ready producer.
//  - Issues them one at a time on the multiplier's start/ready handshake.
//  - Captures each product when the multiplier finishes.
//  - Presents results in issue order on a valid/ready consumer port.
//  Operand/result types: mult_types_pkg operand_t (width_p bits) and result_t (2*width_p bits).
// PARAMETERS
//  DEPTH  4  operand FIFO entries; power of 2, >= 2
// PORTS
//  clk_i               in   1            clock; all state changes on posedge
//  reset_n_i           in   1            synchronous, active-low reset
//  in_valid_i          in   1            operand pair valid
//  in_ready_o          out  1            FIFO can accept a pair
//  in_multiplicand_i   in   width_p      operand A
//  in_multiplier_i     in   width_p      operand B
//  mult_start_o        out  1            one-cycle start pulse to multiplier
//  mult_multiplicand_o out  width_p      FIFO head A; valid when mult_start_o=1
//  mult_multiplier_o   out  width_p      FIFO head B; valid when mult_start_o=1
//  mult_ready_i        in   1            multiplier idle
//  mult_done_i         in   1            multiplier product valid; held until next start
//  mult_product_i      in   2*width_p    multiplier product
//  out_valid_o         out  1            result register full
//  out_ready_i         in   1            consumer accepts result
//  out_product_o       out  2*width_p    result
//  count_o             out  clog2(D)+1   FIFO occupancy
//  busy_o              out  1            FSM in WAIT (multiply in flight)
// BEHAVIOUR
//  Reset (reset_n_i=0 at posedge):
//   - Clears FIFO pointers, count_o=0, FSM=IDLE, out_valid_o=0, out_product_o=0, busy_o=0.
//   - in_ready_o=0 and mult_start_o=0 combinationally while reset_n_i=0.
//  Reset mid-operation: any in-flight or queued operation is discarded and never emitted.
//   The multiplier shares the same reset.
//  FIFO:
//   - push = in_valid_i & in_ready_o; in_ready_o = (count_o != DEPTH).
//   - No pass-through when full.
//   - Push+pop in the same cycle leaves count_o unchanged.
//   - Pointers wrap modulo DEPTH.
//   - Head is registered: a pair pushed into an empty FIFO is issuable the next cycle.
//  FSM states:
//   IDLE:
//    - mult_start_o = (count_o!=0) & mult_ready_i (combinational); pop on the same cycle.
//    - -> WAIT when mult_start_o=1.
//   WAIT:
//    - Capture is allowed when mult_done_i & mult_ready_i & (!out_valid_o | out_ready_i).
//    - On capture: out_product_o<=mult_product_i, out_valid_o<=1, -> IDLE.
//    - Otherwise hold in WAIT. mult_done_i stays high, so the product is never lost.
//    - mult_done_i is ignored in IDLE (stale done from a previous operation).
//  Output port:
//   - out_valid_o clears on out_valid_o & out_ready_i unless a capture occurs in the same cycle.
//   - Capture and drain in the same cycle is allowed: new data loads, out_valid_o stays 1.
//   - out_product_o is stable while out_valid_o & !out_ready_i.
//  Arithmetic: none locally. Products are forwarded unmodified, full 2*width_p bits, no truncation.
//  Latency (push in cycle 0 to empty idle block):
//   - mult_start_o in cycle 1.
//   - Multiplier completes 2*width_p cycles after start, so out_valid_o=1 in cycle 2*width_p+2.
//  Ordering: results leave strictly in push order. At most one operation is in flight.
// CONFIGURATION
//  MULT_DISPATCH_ZERO_SKIP_EN:
//   - Defined: in IDLE with head A==0 or B==0, the head is popped without asserting mult_start_o.
//   - A zero result is written to the output register if (!out_valid_o | out_ready_i); otherwise the entry waits.
//   - FSM stays IDLE. Result appears in cycle 2 after a push to an empty block.
//   - Order is preserved because a skip happens only in IDLE.
//  Undefined: zero operands are issued to the multiplier like any other pair.
// TESTING
//  1 Reset 3 cycles, push 13*11 -> mult_start_o high exactly 1 cycle (cycle 1); out_product_o=143 in cycle 2*width_p+2.
//  2 out_ready_i=0; push DEPTH+2 pairs back-to-back -> in_ready_o=0 once count_o=DEPTH; no pair lost; all results in push order after release.
//  3 Two ops complete with out_ready_i=0 -> first held, FSM stays in WAIT with mult_done_i=1; out_ready_i=1 -> results emitted in order, unchanged.
//  4 A=B=all-ones -> out_product_o = 2^(2*width_p) - 2^(width_p+1) + 1.
//  5 reset_n_i=0 for 1 cycle mid-multiply with 2 queued -> count_o=0, out_valid_o=0; no result afterwards; next push gives a correct product.
//  6 Push 0*57: with MULT_DISPATCH_ZERO_SKIP_EN -> out_product_o=0 in cycle 2, mult_start_o never high; without -> 0 in cycle 2*width_p+2.

Source files
------------

// File: rtl/mult_dispatcher.sv
// mult_dispatcher: operand FIFO plus issue/collect stage around the add-shift multiplier.
// Pairs are queued, issued one at a time, and their products are returned in push order.
// Optional build macro: MULT_DISPATCH_ZERO_SKIP_EN retires pairs with a zero operand
// locally (zero result, no multiplier start).
module mult_dispatcher #(
    parameter int unsigned Width = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [Width-1:0]             in_multiplicand_i,
    input  logic [Width-1:0]             in_multiplier_i,
    output logic                         mult_start_o,
    output logic [Width-1:0]             mult_multiplicand_o,
    output logic [Width-1:0]             mult_multiplier_o,
    input  logic                         mult_ready_i,
    input  logic                         mult_done_i,
    input  logic [2*Width-1:0]           mult_product_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [2*Width-1:0]           out_product_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         busy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

`ifdef MULT_DISPATCH_ZERO_SKIP_EN
    localparam bit ZeroSkip = 1'b1;
`else
    localparam bit ZeroSkip = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                state_q, state_d;
    logic [Width-1:0]      a_mem_q [DEPTH];
    logic [Width-1:0]      b_mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic                  out_valid_q;
    logic [2*Width-1:0]    out_product_q;

    logic push, pop, issue, skip, capture;
    logic out_free, head_zero, fifo_nonempty;

    assign fifo_nonempty       = (count_q != '0);
    assign in_ready_o          = reset_n_i & (count_q != Full);
    assign push                = in_valid_i & in_ready_o;
    assign mult_multiplicand_o = a_mem_q[rd_ptr_q];
    assign mult_multiplier_o   = b_mem_q[rd_ptr_q];
    assign head_zero           = (mult_multiplicand_o == '0) | (mult_multiplier_o == '0);
    // Output register can take a new result if empty or being drained this cycle
    assign out_free            = ~out_valid_q | out_ready_i;
    assign pop                 = issue | skip;

    assign mult_start_o  = issue;
    assign out_valid_o   = out_valid_q;
    assign out_product_o = out_product_q;
    assign count_o       = count_q;
    assign busy_o        = (state_q == StWait);

    // Next-state and issue/capture decisions; everything is held off during reset
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        skip    = 1'b0;
        capture = 1'b0;
        if (reset_n_i) begin
            case (state_q)
                StIdle: begin
                    if (fifo_nonempty) begin
                        if (ZeroSkip && head_zero) begin
                            // Zero-operand pair waits here until the output register frees
                            skip = out_free;
                        end else if (mult_ready_i) begin
                            issue   = 1'b1;
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    // Done is held by the multiplier, so stalling here never loses a product
                    if (mult_done_i && mult_ready_i && out_free) begin
                        capture = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state_q <= StIdle;
        else            state_q <= state_d;
    end

    // Operand storage; contents need no reset since pointers/count gate their use
    always_ff @(posedge clk_i) begin
        if (push) begin
            a_mem_q[wr_ptr_q] <= in_multiplicand_i;
            b_mem_q[wr_ptr_q] <= in_multiplier_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Result register: load on capture or skip, otherwise clear when drained
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else if (capture) begin
            out_valid_q   <= 1'b1;
            out_product_q <= mult_product_i;
        end else if (skip) begin
            out_valid_q   <= 1'b1;
            out_product_q <= '0;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_q   <= 1'b0;
        end
    end

endmodule
